// File: rtl/qsys_nios2_gen2_cpu_ocimem_pkg.sv
// Shared definitions for the OCI debug RAM arbiter: default widths, jdo field
// positions, requester tags and grant FSM states.
package qsys_nios2_gen2_cpu_ocimem_pkg;

  localparam int OCI_ADDR_W   = 8;
  localparam int OCI_DATA_W   = 32;
  localparam int JDO_W        = 38;
  localparam int JDO_ADDR_LSB = 18;
  localparam int JDO_ADDR_MSB = 25;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_DATA_MSB = 34;
  localparam int JDO_RD_BIT   = 35;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_JTAG = 2'd1,
    REQ_AVS  = 2'd2
  } req_e;

  typedef enum logic [1:0] {
    GS_IDLE       = 2'd0,
    GS_JTAG_PRI   = 2'd1,
    GS_AVS_FORCED = 2'd2
  } grant_state_e;

endpackage

// File: rtl/qsys_nios2_gen2_cpu_ocimem_grant.sv
// Grant arbiter between the JTAG pending slot and the Avalon debug slave.
// JTAG wins contention until it has taken MAX_JTAG_STREAK grants in a row.
module qsys_nios2_gen2_cpu_ocimem_grant
  import qsys_nios2_gen2_cpu_ocimem_pkg::*;
#(
  parameter int MAX_JTAG_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic jtag_req,
  input  logic avs_req,
  output logic jtag_gnt,
  output logic avs_gnt
);

  localparam int STREAK_W = $clog2(MAX_JTAG_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_JTAG_STREAK);

  grant_state_e          state_q, state_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;

  always_comb begin
    jtag_gnt = jtag_req & ~(avs_req & (state_q == GS_AVS_FORCED));
    avs_gnt  = avs_req & ~jtag_gnt;

    streak_d = streak_q;
    if (!avs_req || avs_gnt) begin
      streak_d = '0;
    end else if (jtag_gnt && streak_q != STREAK_MAX) begin
      streak_d = streak_q + STREAK_W'(1);
    end

    state_d = state_q;
    unique case (state_q)
      GS_IDLE: begin
        if (streak_d == STREAK_MAX) state_d = GS_AVS_FORCED;
        else if (jtag_req)          state_d = GS_JTAG_PRI;
      end
      GS_JTAG_PRI: begin
        if (streak_d == STREAK_MAX) state_d = GS_AVS_FORCED;
        else if (!jtag_req)         state_d = GS_IDLE;
      end
      GS_AVS_FORCED: begin
        // Leaves once Avalon has had its turn (or withdrew its request).
        if (avs_gnt || !avs_req) state_d = jtag_req ? GS_JTAG_PRI : GS_IDLE;
      end
      default: state_d = GS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= GS_IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/qsys_nios2_gen2_cpu_ocimem_arbiter.sv
// OCI debug RAM arbiter: JTAG command slot, address counter, RAM port muxing
// and routing of read data back to the JTAG monitor or the Avalon slave.
module qsys_nios2_gen2_cpu_ocimem_arbiter
  import qsys_nios2_gen2_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W          = OCI_ADDR_W,
  parameter int DATA_W          = OCI_DATA_W,
  parameter int MAX_JTAG_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [JDO_W-1:0]  jdo,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] mon_dreg,
  output logic              mon_ready,
  output logic              jtag_overrun
);

  logic              pend_q, pend_d;
  logic              pend_wr_q, pend_wr_d;
  logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
  logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
  logic              overrun_q, overrun_d;
  req_e              rd_tag_q, rd_tag_d;
  logic [DATA_W-1:0] mon_dreg_q, mon_dreg_d;

  logic jtag_req, avs_req, jtag_gnt, avs_gnt;
  logic jdo_unused;

  assign jdo_unused = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_DATA_LSB-1:0]};

  assign jtag_req = pend_q & ~reset;
  assign avs_req  = (avs_read | avs_write) & ~reset;

  qsys_nios2_gen2_cpu_ocimem_grant #(
    .MAX_JTAG_STREAK (MAX_JTAG_STREAK)
  ) u_grant (
    .clk      (clk),
    .reset    (reset),
    .jtag_req (jtag_req),
    .avs_req  (avs_req),
    .jtag_gnt (jtag_gnt),
    .avs_gnt  (avs_gnt)
  );

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    rd_tag_d  = REQ_NONE;
    if (jtag_gnt) begin
      ram_addr  = jtag_addr_q;
      ram_we    = pend_wr_q;
      ram_wdata = pend_wdata_q;
      rd_tag_d  = pend_wr_q ? REQ_NONE : REQ_JTAG;
    end else if (avs_gnt) begin
      // A simultaneous read+write is a write; the read is dropped.
      ram_addr  = avs_address;
      ram_we    = avs_write;
      ram_wdata = avs_writedata;
      rd_tag_d  = avs_write ? REQ_NONE : REQ_AVS;
    end
    avs_waitrequest = reset | (avs_req & ~avs_gnt);
  end

  always_comb begin
    pend_d       = pend_q & ~jtag_gnt;
    pend_wr_d    = pend_wr_q;
    pend_wdata_d = pend_wdata_q;
    overrun_d    = overrun_q;
    jtag_addr_d  = jtag_gnt ? jtag_addr_q + ADDR_W'(1) : jtag_addr_q;
    // The slot counts as free in the cycle its entry is being granted.
    if ((take_action_ocimem_a | take_action_ocimem_b) && pend_d) begin
      overrun_d = 1'b1;
    end else begin
      if (take_action_ocimem_a) begin
        jtag_addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
        if (jdo[JDO_RD_BIT]) begin
          pend_d    = 1'b1;
          pend_wr_d = 1'b0;
        end
      end
      if (take_action_ocimem_b) begin
        pend_d       = 1'b1;
        pend_wr_d    = 1'b1;
        pend_wdata_d = jdo[JDO_DATA_LSB +: DATA_W];
      end
    end
  end

  always_comb begin
    mon_ready         = (rd_tag_q == REQ_JTAG) & ~reset;
    avs_readdatavalid = (rd_tag_q == REQ_AVS) & ~reset;
    avs_readdata      = avs_readdatavalid ? ram_rdata : '0;
    mon_dreg_d        = reset ? '0 : (mon_ready ? ram_rdata : mon_dreg_q);
    mon_dreg          = mon_dreg_d;
    jtag_overrun      = overrun_q & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= 1'b0;
      pend_wr_q   <= 1'b0;
      jtag_addr_q <= '0;
      overrun_q   <= 1'b0;
      rd_tag_q    <= REQ_NONE;
    end else begin
      pend_q      <= pend_d;
      pend_wr_q   <= pend_wr_d;
      jtag_addr_q <= jtag_addr_d;
      overrun_q   <= overrun_d;
      rd_tag_q    <= rd_tag_d;
    end
    pend_wdata_q <= pend_wdata_d;
    mon_dreg_q   <= mon_dreg_d;
  end

endmodule

// File: tb/tb_qsys_nios2_gen2_cpu_ocimem_arbiter.sv
// Bench for the OCI debug RAM arbiter: behavioural RAM, Avalon vector table,
// and hand sequences for JTAG reads, fairness/overrun, wrap and reset cases.
module tb_qsys_nios2_gen2_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        take_a, take_b;
  logic [37:0] jdo;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mon_dreg;
  logic        mon_ready;
  logic        jtag_overrun;

  always #5 clk = ~clk;

  qsys_nios2_gen2_cpu_ocimem_arbiter #(
    .ADDR_W(8), .DATA_W(32), .MAX_JTAG_STREAK(4)
  ) dut (
    .clk(clk), .reset(reset),
    .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b), .jdo(jdo),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .mon_dreg(mon_dreg), .mon_ready(mon_ready), .jtag_overrun(jtag_overrun)
  );

  // RAM with one-cycle read latency plus a preload port owned by the bench.
  logic [31:0] mem [256];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  logic [31:0] model [256];
  logic [31:0] sb_avs[$];
  logic [31:0] sb_mon[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d; model[a] = d;
    tick();
    pre_we = 1'b0;
  endtask

  function automatic logic [37:0] ja(input logic rd, input logic [7:0] a);
    logic [37:0] j;
    j = '0; j[35] = rd; j[25:18] = a;
    return j;
  endfunction

  function automatic logic [37:0] jb(input logic [31:0] d);
    logic [37:0] j;
    j = '0; j[34:3] = d;
    return j;
  endfunction

  // Scoreboard consumers: every returned read must match the oldest expectation.
  always @(negedge clk) begin
    logic [31:0] e;
    if (avs_readdatavalid) begin
      checks++;
      if (sb_avs.size() == 0) begin
        errors++;
        $display("FAIL avs_rdata: unexpected readdatavalid data=%h expected none", avs_readdata);
      end else begin
        e = sb_avs.pop_front();
        if (avs_readdata !== e) begin
          errors++;
          $display("FAIL avs_rdata: got %h expected %h", avs_readdata, e);
        end
      end
    end
    if (mon_ready) begin
      checks++;
      if (sb_mon.size() == 0) begin
        errors++;
        $display("FAIL mon_dreg: unexpected mon_ready data=%h expected none", mon_dreg);
      end else begin
        e = sb_mon.pop_front();
        if (mon_dreg !== e) begin
          errors++;
          $display("FAIL mon_dreg: got %h expected %h", mon_dreg, e);
        end
      end
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        exp_wait;
    logic        exp_we;
    logic [7:0]  exp_addr;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int acc_c;
    logic acc;

    vecs[0] = '{1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b1, 8'h10};
    vecs[1] = '{1'b1, 1'b0, 8'h10, 32'h0,        1'b0, 1'b0, 8'h10};
    vecs[2] = '{1'b0, 1'b1, 8'h11, 32'hCAFEF00D, 1'b0, 1'b1, 8'h11};
    vecs[3] = '{1'b1, 1'b0, 8'h11, 32'h0,        1'b0, 1'b0, 8'h11};
    vecs[4] = '{1'b1, 1'b0, 8'h10, 32'h0,        1'b0, 1'b0, 8'h10};
    vecs[5] = '{1'b1, 1'b1, 8'h12, 32'hA5A5A5A5, 1'b0, 1'b1, 8'h12};
    vecs[6] = '{1'b1, 1'b0, 8'h12, 32'h0,        1'b0, 1'b0, 8'h12};
    vecs[7] = '{1'b0, 1'b0, 8'h33, 32'h0,        1'b0, 1'b0, 8'h00};
    vecs[8] = '{1'b0, 1'b1, 8'hFF, 32'h0BADF00D, 1'b0, 1'b1, 8'hFF};
    vecs[9] = '{1'b1, 1'b0, 8'hFF, 32'h0,        1'b0, 1'b0, 8'hFF};

    reset = 1'b1; take_a = 1'b0; take_b = 1'b0; jdo = '0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    for (int i = 0; i < 256; i++) model[i] = '0;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_waitrequest", {31'b0, avs_waitrequest}, 32'd1);
    chk("rst_readdatavalid", {31'b0, avs_readdatavalid}, 32'd0);
    chk("rst_readdata", avs_readdata, 32'd0);
    chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("rst_ram_addr", {24'b0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_mon_dreg", mon_dreg, 32'd0);
    chk("rst_mon_ready", {31'b0, mon_ready}, 32'd0);
    chk("rst_overrun", {31'b0, jtag_overrun}, 32'd0);
    tick();
    reset = 1'b0;

    preload(8'h20, 32'h12345678);
    preload(8'h45, 32'hFFFF0000);
    preload(8'h80, 32'h80808080);
    preload(8'h21, 32'h0);
    preload(8'h00, 32'h0);

    // Uncontended Avalon vectors, one per cycle.
    for (int i = 0; i < 10; i++) begin
      avs_read = vecs[i].rd; avs_write = vecs[i].wr;
      avs_address = vecs[i].addr; avs_writedata = vecs[i].wdata;
      if (vecs[i].wr) model[vecs[i].addr] = vecs[i].wdata;
      else if (vecs[i].rd) sb_avs.push_back(model[vecs[i].addr]);
      @(negedge clk);
      chk($sformatf("vec%0d_wait", i), {31'b0, avs_waitrequest}, {31'b0, vecs[i].exp_wait});
      chk($sformatf("vec%0d_we", i), {31'b0, ram_we}, {31'b0, vecs[i].exp_we});
      chk($sformatf("vec%0d_addr", i), {24'b0, ram_addr}, {24'b0, vecs[i].exp_addr});
      if (vecs[i].wr) chk($sformatf("vec%0d_wdata", i), ram_wdata, vecs[i].wdata);
      tick();
    end
    avs_read = 1'b0; avs_write = 1'b0;
    repeat (2) tick();

    // JTAG read of 0x20, then a write that must land at the incremented address.
    take_a = 1'b1; jdo = ja(1'b1, 8'h20);
    sb_mon.push_back(model[8'h20]);
    @(negedge clk);
    chk("jrd_ready_n", {31'b0, mon_ready}, 32'd0);
    tick();
    take_a = 1'b0;
    @(negedge clk);
    chk("jrd_ram_addr", {24'b0, ram_addr}, 32'h20);
    chk("jrd_ram_we", {31'b0, ram_we}, 32'd0);
    chk("jrd_ready_n1", {31'b0, mon_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("jrd_ready_n2", {31'b0, mon_ready}, 32'd1);
    tick();
    take_b = 1'b1; jdo = jb(32'h55AA55AA);
    @(negedge clk);
    chk("jrd_ready_drop", {31'b0, mon_ready}, 32'd0);
    chk("jrd_dreg_hold", mon_dreg, 32'h12345678);
    tick();
    take_b = 1'b0;
    @(negedge clk);
    chk("jwr_ram_addr", {24'b0, ram_addr}, 32'h21);
    chk("jwr_ram_we", {31'b0, ram_we}, 32'd1);
    chk("jwr_ram_wdata", ram_wdata, 32'h55AA55AA);
    tick();
    tick();
    model[8'h21] = 32'h55AA55AA;
    chk("jwr_mem21", mem[8'h21], 32'h55AA55AA);

    // Sustained JTAG writes against a held Avalon read.
    @(negedge clk);
    chk("fair_overrun_pre", {31'b0, jtag_overrun}, 32'd0);
    tick();
    take_a = 1'b1; jdo = ja(1'b0, 8'h40);
    tick();
    take_a = 1'b0;
    acc = 1'b0; acc_c = 0;
    for (int c = 1; c <= 8; c++) begin
      take_b = (c <= 6);
      jdo = jb(32'h1000 + 32'(c - 1));
      avs_address = 8'h80;
      avs_read = (c >= 2) && !acc;
      @(negedge clk);
      if (avs_read && !avs_waitrequest) begin
        acc = 1'b1; acc_c = c;
        sb_avs.push_back(model[8'h80]);
      end
      tick();
    end
    take_b = 1'b0; avs_read = 1'b0;
    chk("fair_accept_cycle", acc_c, 32'd6);
    for (int k = 0; k < 5; k++) begin
      model[8'h40 + 8'(k)] = 32'h1000 + 32'(k);
      chk($sformatf("fair_mem%0d", k), mem[8'h40 + 8'(k)], 32'h1000 + 32'(k));
    end
    chk("ovr_dropped_write", mem[8'h45], 32'hFFFF0000);
    repeat (2) tick();
    @(negedge clk);
    chk("ovr_sticky", {31'b0, jtag_overrun}, 32'd1);
    tick();

    reset = 1'b1;
    @(negedge clk);
    chk("ovr_rst_force", {31'b0, jtag_overrun}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("ovr_rst_clear", {31'b0, jtag_overrun}, 32'd0);
    tick();

    // Address counter wrap from 0xFF to 0x00.
    take_a = 1'b1; jdo = ja(1'b0, 8'hFF);
    tick();
    take_a = 1'b0; take_b = 1'b1; jdo = jb(32'hA1A1A1A1);
    tick();
    take_b = 1'b0;
    tick();
    take_b = 1'b1; jdo = jb(32'hB2B2B2B2);
    tick();
    take_b = 1'b0;
    tick();
    chk("wrap_memFF", mem[8'hFF], 32'hA1A1A1A1);
    chk("wrap_mem00", mem[8'h00], 32'hB2B2B2B2);
    @(negedge clk);
    chk("wrap_no_overrun", {31'b0, jtag_overrun}, 32'd0);
    tick();

    // Reset asserted while an Avalon read is in flight.
    avs_read = 1'b1; avs_address = 8'h10;
    @(negedge clk);
    chk("rmid_accept", {31'b0, avs_waitrequest}, 32'd0);
    tick();
    avs_read = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rmid_valid", {31'b0, avs_readdatavalid}, 32'd0);
    chk("rmid_rdata", avs_readdata, 32'd0);
    chk("rmid_wait", {31'b0, avs_waitrequest}, 32'd1);
    chk("rmid_we", {31'b0, ram_we}, 32'd0);
    chk("rmid_addr", {24'b0, ram_addr}, 32'd0);
    chk("rmid_wdata", ram_wdata, 32'd0);
    chk("rmid_mon_dreg", mon_dreg, 32'd0);
    chk("rmid_mon_ready", {31'b0, mon_ready}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rmid_valid_after", {31'b0, avs_readdatavalid}, 32'd0);
    tick();

    repeat (3) tick();
    chk("sb_avs_drained", 32'(sb_avs.size()), 32'd0);
    chk("sb_mon_drained", 32'(sb_mon.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/qsys_nios2_gen2_cpu_ocimem_arbiter.md
# qsys_nios2_gen2_cpu_ocimem_arbiter

Arbitrates the Nios II on-chip-instrumentation (OCI) debug RAM between two requesters. The first is the JTAG debug path, which drives the `take_action_ocimem_a/b` strobes and the `jdo` shift data from the debug-slave sysclk stage. The second is the CPU-side Avalon debug slave. The block owns the single RAM port, returns read data to the JTAG monitor (`mon_dreg`/`mon_ready`) and to Avalon (`avs_readdata`/`avs_readdatavalid`), and guarantees Avalon forward progress under sustained JTAG traffic.

## Interface
- `ADDR_W`, default 8: OCI RAM word-address width (256 words).
- `DATA_W`, default 32: RAM / monitor data width.
- `MAX_JTAG_STREAK`, default 4: maximum number of consecutive JTAG grants while Avalon is waiting.
- `clk`  in  1  sole clock. One clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous active-high reset.
- `take_action_ocimem_a`  in  1  JTAG address/read command strobe, one cycle.
- `take_action_ocimem_b`  in  1  JTAG write-data command strobe, one cycle.
- `jdo`  in  38  JTAG data:
  - `jdo[25:18]`: address.
  - `jdo[34:3]`: write data.
  - `jdo[35]`: read-request flag on an `_a` strobe.
- `avs_address`  in  ADDR_W  Avalon word address.
- `avs_read`, `avs_write`  in  1  Avalon commands, held until accepted.
- `avs_writedata`  in  DATA_W  Avalon write data.
- `avs_waitrequest`  out  1  request not accepted this cycle.
- `avs_readdata`  out  DATA_W  read data.
- `avs_readdatavalid`  out  1  read data valid.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data, one-cycle latency.
- `mon_dreg`  out  DATA_W  last JTAG read result.
- `mon_ready`  out  1  one-cycle pulse when `mon_dreg` is updated.
- `jtag_overrun`  out  1  sticky; a new JTAG command arrived while one was still pending.

## Operation
- JTAG `_a` strobe:
  - `jtag_addr` ← `jdo[25:18]`.
  - If `jdo[35]`=1, set the pending JTAG read.
- JTAG `_b` strobe: set the pending JTAG write with data `jdo[34:3]` at `jtag_addr`.
- JTAG pending slot:
  - Single-entry.
  - A strobe arriving while the slot is occupied sets `jtag_overrun` and is dropped.
  - `jtag_overrun` clears only on reset.
- `jtag_addr` increments (mod 2^ADDR_W) after each granted JTAG access; 255 wraps to 0.
- Avalon request = `avs_read | avs_write`. If both are high, the request is treated as a write and the read is ignored.
- Arbitration each cycle:
  - JTAG pending and Avalon requesting, `streak` < MAX_JTAG_STREAK → grant JTAG.
  - JTAG pending and Avalon requesting, `streak` = MAX_JTAG_STREAK → grant Avalon.
  - Only one requester active → grant it.
- `streak` counter:
  - +1 on a JTAG grant while Avalon is requesting.
  - Cleared on an Avalon grant, or in any cycle without an Avalon request.
  - Saturates at MAX_JTAG_STREAK.
- Grant drives `ram_addr`, `ram_we`, `ram_wdata` combinationally from the winner. With no grant, `ram_we`=0.
- Read return tag register `rd_tag ∈ {NONE, JTAG, AVS}` is loaded on each read grant and cleared otherwise. The next cycle routes `ram_rdata` accordingly.
- Grant FSM (within `qsys_nios2_gen2_cpu_ocimem_grant`):
  - States: `IDLE`, `JTAG_PRI`, `AVS_FORCED`.
  - `IDLE` → `JTAG_PRI` when a JTAG request is pending.
  - `JTAG_PRI` → `AVS_FORCED` when `streak` hits the limit.
  - `AVS_FORCED` → `JTAG_PRI`/`IDLE` after the Avalon grant.
  - `JTAG_PRI` → `IDLE` when no JTAG request is pending.

## Timing
- Avalon accept: `avs_waitrequest` = request & ~avalon_grant, combinational, so a grant is accepted in the same cycle.
- Avalon read accepted in cycle N → `avs_readdatavalid`=1 with data in cycle N+1.
- Avalon throughput: back-to-back accepts at one per cycle when uncontended.
- JTAG read path:
  - Strobe in cycle N → pending in N+1.
  - Earliest grant N+1 → `mon_ready` pulse with `mon_dreg` valid in N+2.
  - Under contention, extra delay is at most one cycle per forced Avalon grant.
- Write to address A followed by a read of A in the next cycle returns the new data.
- Reset values:
  - Forced to 0: `mon_dreg`, `mon_ready`, `jtag_overrun`, `avs_readdatavalid`, `avs_readdata`, `ram_we`, `ram_addr`, `ram_wdata`.
  - Forced to 1: `avs_waitrequest`.
  - Cleared: pending slot, `streak`, `rd_tag`.
  - FSM returns to `IDLE`.
- Reset during an in-flight read (tag set): no valid/ready pulse is produced after reset deasserts.

## Structure
- Shared package holds:
  - `ADDR_W` and `DATA_W` defaults.
  - `jdo` field bit positions (ADDR 25:18, DATA 34:3, RD 35).
  - Requester enum {NONE, JTAG, AVS}.
  - Grant FSM state enum.
- One sub-module, `qsys_nios2_gen2_cpu_ocimem_grant`, holds the FSM, `streak` counter and grant outputs. The top level holds the JTAG slot, address counter, datapath muxes and return routing.

## Test plan
- Uncontended Avalon path: write 0xDEADBEEF to 0x10, then read 0x10 → `avs_waitrequest`=0 both cycles; `avs_readdatavalid` one cycle later with 0xDEADBEEF.
- JTAG read: `_a` with `jdo[25:18]`=0x20 and `jdo[35]`=1, RAM[0x20]=0x12345678 → `mon_ready` 2 cycles later, `mon_dreg`=0x12345678, `jtag_addr`=0x21.
- Fairness: JTAG commands every cycle plus a held Avalon read, MAX_JTAG_STREAK=4 → Avalon is granted on the 5th contended cycle; no Avalon wait exceeds 5 cycles.
- Overrun and wrap:
  - Second `_b` strobe while the first is still pending → `jtag_overrun`=1 and stays set; the first write lands, the second does not.
  - `jtag_addr`=0xFF then a write → address wraps to 0x00.
- Reset mid-read and dual command:
  - Assert `reset` the cycle after an Avalon read is granted → no `avs_readdatavalid`; all outputs at reset values.
  - `avs_read`=`avs_write`=1 → write performed, no read data returned.
